// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback stage
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_COMMIT    = 2'b10
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// rtl/wb_stage_load_ext.sv - selects and sign/zero-extends load data from an aligned word
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: holds loads for memory data, drives the register file write port
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_result_src,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_pc_plus4,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              we3,
  output logic [REG_AW-1:0] a3,
  output logic [XLEN-1:0]   wd3,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_rd
);

  wb_state_t         state;
  logic [REG_AW-1:0] rd;
  logic              reg_write;
  logic [1:0]        result_src;
  logic [2:0]        funct3;
  logic [1:0]        addr;
  logic [XLEN-1:0]   value;

  logic              accept;
  logic              in_is_load;
  logic [XLEN-1:0]   in_value;
  logic [XLEN-1:0]   load_data;

  assign in_ready   = (state != ST_LOAD_WAIT);
  assign accept     = in_valid & in_ready;
  assign in_is_load = (in_result_src == RES_LOAD);
  // Reserved result_src code falls through to the ALU result.
  assign in_value   = (in_result_src == RES_PC4) ? in_pc_plus4 : in_alu_result;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3 (funct3),
    .off    (addr),
    .rdata  (dmem_rdata),
    .data   (load_data)
  );

  // Outputs are loaded on the edge that enters COMMIT so we3 lasts exactly that cycle
  // and a3/wd3 keep their last committed values afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rd         <= '0;
      reg_write  <= 1'b0;
      result_src <= 2'b00;
      funct3     <= 3'b000;
      addr       <= 2'b00;
      value      <= '0;
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
    end else begin
      we3 <= 1'b0;
      case (state)
        ST_IDLE, ST_COMMIT: begin
          if (accept) begin
            rd         <= in_rd;
            reg_write  <= in_reg_write;
            result_src <= in_result_src;
            funct3     <= in_funct3;
            addr       <= in_alu_result[1:0];
            if (in_is_load) begin
              state <= ST_LOAD_WAIT;
            end else begin
              value <= in_value;
              state <= ST_COMMIT;
              we3   <= in_reg_write & (in_rd != '0);
              a3    <= in_rd;
              wd3   <= in_value;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD_WAIT: begin
          if (dmem_rvalid && result_src == RES_LOAD) begin
            value <= load_data;
            state <= ST_COMMIT;
            we3   <= reg_write & (rd != '0);
            a3    <= rd;
            wd3   <= load_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fwd_valid  = we3;
  assign fwd_rd     = a3;
  assign fwd_data   = wd3;
  assign pend_valid = (state == ST_LOAD_WAIT) & reg_write & (rd != '0);
  assign pend_rd    = rd;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for the writeback stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_result_src;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        pend_valid;
  logic [4:0]  pend_rd;

  int errors = 0;
  int checks = 0;
  logic [36:0] sb[$];
  logic [36:0] exp_commit;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .in_result_src (in_result_src),
    .in_funct3     (in_funct3),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .we3           (we3),
    .a3            (a3),
    .wd3           (wd3),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .pend_valid    (pend_valid),
    .pend_rd       (pend_rd)
  );

  // Every committed write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we3 === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: a3=%0d wd3=%h, required no write", a3, wd3);
      end else begin
        exp_commit = sb.pop_front();
        if ({a3, wd3} !== exp_commit) begin
          errors++;
          $display("FAIL commit_data: a3=%0d wd3=%h, required a3=%0d wd3=%h",
                   a3, wd3, exp_commit[36:32], exp_commit[31:0]);
        end
      end
      checks++;
      if (fwd_valid !== 1'b1 || fwd_rd !== a3 || fwd_data !== wd3) begin
        errors++;
        $display("FAIL fwd_match: fwd=%b/%0d/%h, required 1/%0d/%h",
                 fwd_valid, fwd_rd, fwd_data, a3, wd3);
      end
    end
  end

  task automatic drive_entry(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                             input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b1; in_reg_write = rw; in_rd = rd; in_result_src = src;
    in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc4;
    if (src != 2'b01 && rw && rd != 0) sb.push_back({rd, (src == 2'b10) ? pc4 : alu});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic rw, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] rdata,
                         input logic [31:0] expv, input int wait_n);
    drive_entry(rw, rd, 2'b01, f3, {30'h1000_0000, off}, 32'h0);
    repeat (wait_n) begin
      @(negedge clk);
      checks++;
      if (pend_valid !== (rw && rd != 0) || pend_rd !== rd || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_wait: pend=%b/%0d ready=%b, required %b/%0d/0",
                 pend_valid, pend_rd, in_ready, (rw && rd != 0), rd);
      end
    end
    // Upstream holds a new entry while data returns; it must not be taken this cycle.
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd31; in_result_src = 2'b00;
    in_alu_result = 32'hBAD0_0001;
    if (rw && rd != 0) sb.push_back({rd, expv});
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0; in_valid = 1'b0; dmem_rdata = $urandom;
    checks++;
    if (we3 !== (rw && rd != 0) || a3 !== rd || wd3 !== expv) begin
      errors++;
      $display("FAIL load_commit: we3=%b a3=%0d wd3=%h, required %b/%0d/%h",
               we3, a3, wd3, (rw && rd != 0), rd, expv);
    end
    @(posedge clk);
    #1;
    checks++;
    if (we3 !== 1'b0 || pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_after: we3=%b pend=%b, required 0/0", we3, pend_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_result_src = '0;
    in_funct3 = '0; in_alu_result = '0; in_pc_plus4 = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #2;
    checks++;
    if ({we3, a3, wd3, fwd_valid, fwd_rd, fwd_data, pend_valid, pend_rd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we3=%b a3=%0d wd3=%h pend=%b, required all zero",
               we3, a3, wd3, pend_valid);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_alu();
    drive_entry(1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0);
    @(negedge clk);
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'h1234 || fwd_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_commit: we3=%b a3=%0d wd3=%h fwd=%b, required 1/5/00001234/1",
               we3, a3, wd3, fwd_valid);
    end
    @(negedge clk);
    checks++;
    if (we3 !== 1'b0 || a3 !== 5'd5 || wd3 !== 32'h1234) begin
      errors++;
      $display("FAIL alu_hold: we3=%b a3=%0d wd3=%h, required 0/5/00001234", we3, a3, wd3);
    end
  endtask

  task automatic test_loads();
    do_load(1'b1, 5'd7,  3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80, 3);
    do_load(1'b1, 5'd8,  3'b101, 2'd2, 32'h9ABC_1234, 32'h0000_9ABC, 1);
    do_load(1'b1, 5'd9,  3'b001, 2'd2, 32'h9ABC_1234, 32'hFFFF_9ABC, 2);
    do_load(1'b1, 5'd10, 3'b100, 2'd1, 32'h0000_A500, 32'h0000_00A5, 1);
    do_load(1'b1, 5'd11, 3'b001, 2'd0, 32'h1234_8765, 32'hFFFF_8765, 1);
    do_load(1'b1, 5'd12, 3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    do_load(1'b1, 5'd13, 3'b011, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    do_load(1'b0, 5'd14, 3'b010, 2'd0, 32'h5555_AAAA, 32'h5555_AAAA, 2);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
      end
      in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'(i); in_result_src = 2'b00;
      in_alu_result = 32'hA000_0000 + 32'(i);
      sb.push_back({5'(i), 32'hA000_0000 + 32'(i)});
      @(posedge clk);
      #1;
      checks++;
      if (we3 !== 1'b1 || a3 !== 5'(i)) begin
        errors++;
        $display("FAIL b2b_commit: we3=%b a3=%0d, required 1/%0d", we3, a3, i);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (we3 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: we3=%b, required 0", we3);
    end
  endtask

  task automatic test_x0_and_pc4();
    drive_entry(1'b1, 5'd0, 2'b00, 3'b000, 32'h7777_7777, 32'h0);
    @(negedge clk);
    checks++;
    if (we3 !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL x0_suppress: we3=%b fwd=%b, required 0/0", we3, fwd_valid);
    end
    drive_entry(1'b1, 5'd1, 2'b10, 3'b000, 32'h0000_0F00, 32'h0000_0104);
    @(negedge clk);
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd1 || wd3 !== 32'h104) begin
      errors++;
      $display("FAIL pc4_commit: we3=%b a3=%0d wd3=%h, required 1/1/00000104", we3, a3, wd3);
    end
    drive_entry(1'b1, 5'd9, 2'b11, 3'b000, 32'h0000_ABCD, 32'h0000_0200);
    @(negedge clk);
    checks++;
    if (we3 !== 1'b1 || wd3 !== 32'hABCD) begin
      errors++;
      $display("FAIL reserved_src: we3=%b wd3=%h, required 1/0000abcd", we3, wd3);
    end
  endtask

  task automatic test_reset_in_wait();
    drive_entry(1'b1, 5'd3, 2'b01, 3'b010, 32'h0000_0000, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pend_valid !== 1'b0 || we3 !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait: pend=%b we3=%b ready=%b, required 0/0/1",
               pend_valid, we3, in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    @(posedge clk);
    #1 dmem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (we3 !== 1'b0 || pend_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stray_rvalid: we3=%b pend=%b ready=%b, required 0/0/1",
                 we3, pend_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_back_to_back();
    test_x0_and_pc4();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
